// File: rtl/ht_vote_list.sv
// ht_vote_list: Hough (rho, theta) accumulator kept as a singly linked list
// in on-chip arrays. Supports vote (search then increment or append),
// search, show-by-slot and clear, and tracks the highest-count cell.
//
// Handshake: a command strobe is taken only when the FSM is idle and busy_o
// is low. busy_o rises the cycle after acceptance and stays high through the
// single-cycle done_o pulse. Result outputs are registered and hold until
// the next done_o.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   rho_i, theta_i            command key (key = {theta, rho}, unsigned)
//   vote_i, search_i, show_i, clear_i
//                             command strobes, priority clear > vote > search > show
//   addr_i                    physical slot for show
//   busy_o, done_o            operation in flight / completion pulse
//   found_o, overflow_o       key hit or slot valid / vote miss on a full list
//   cnt_o, slot_o, next_o     result count, slot, next pointer (show only)
//   len_o                     number of nodes in the list
//   best_rho_o, best_theta_o, best_cnt_o
//                             highest-count cell seen since reset/clear
module ht_vote_list #(
   parameter int RHO_W   = 10,
   parameter int THETA_W = 8,
   parameter int CNT_W   = 12,
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int SORTED  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [RHO_W-1:0]   rho_i,
   input  logic [THETA_W-1:0] theta_i,
   input  logic               vote_i,
   input  logic               search_i,
   input  logic               show_i,
   input  logic               clear_i,
   input  logic [ADDR_W-1:0]  addr_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               found_o,
   output logic               overflow_o,
   output logic [CNT_W-1:0]   cnt_o,
   output logic [ADDR_W-1:0]  slot_o,
   output logic [ADDR_W-1:0]  next_o,
   output logic [ADDR_W:0]    len_o,
   output logic [RHO_W-1:0]   best_rho_o,
   output logic [THETA_W-1:0] best_theta_o,
   output logic [CNT_W-1:0]   best_cnt_o
);

   localparam int KEY_W = THETA_W + RHO_W;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_HIT, S_MISS, S_SHOW, S_CLEAR
   } state_t;

   // Node storage: not reset, slots at or above len_q are treated as invalid.
   logic [KEY_W-1:0]  key_mem  [DEPTH];
   logic [CNT_W-1:0]  cnt_mem  [DEPTH];
   logic [ADDR_W-1:0] next_mem [DEPTH];

   state_t            state_q;
   logic [KEY_W-1:0]  key_q;
   logic              is_vote_q;
   logic [ADDR_W-1:0] ptr_q, prev_q, head_q, tail_q, addr_q;
   logic              prev_vld_q;
   logic              at_tail_q;    // miss insert point is after the tail
   logic [ADDR_W:0]   len_q;
   logic              busy_q, done_q, found_q, overflow_q;
   logic [CNT_W-1:0]  cnt_q, best_cnt_q;
   logic [ADDR_W-1:0] slot_q, next_q;
   logic [RHO_W-1:0]  best_rho_q;
   logic [THETA_W-1:0] best_theta_q;

   logic [IDX_W-1:0]  ptr_ix, prev_ix, tail_ix, new_ix, addr_ix;
   logic [KEY_W-1:0]  cur_key;
   logic [CNT_W-1:0]  cur_cnt, inc_cnt;
   logic [ADDR_W-1:0] new_slot;
   logic              show_vld, list_full;

   assign ptr_ix   = ptr_q[IDX_W-1:0];
   assign prev_ix  = prev_q[IDX_W-1:0];
   assign tail_ix  = tail_q[IDX_W-1:0];
   assign addr_ix  = addr_q[IDX_W-1:0];
   assign new_ix   = len_q[IDX_W-1:0];
   assign new_slot = len_q[ADDR_W-1:0];
   assign cur_key  = key_mem[ptr_ix];
   assign cur_cnt  = cnt_mem[ptr_ix];
   assign inc_cnt  = (cur_cnt == CNT_MAX) ? CNT_MAX : cur_cnt + CNT_W'(1);
   assign show_vld = ({1'b0, addr_q} < len_q);
   assign list_full = (len_q == LEN_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         key_q        <= '0;
         is_vote_q    <= 1'b0;
         ptr_q        <= '0;
         prev_q       <= '0;
         prev_vld_q   <= 1'b0;
         at_tail_q    <= 1'b0;
         addr_q       <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         len_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         found_q      <= 1'b0;
         overflow_q   <= 1'b0;
         cnt_q        <= '0;
         slot_q       <= '0;
         next_q       <= '0;
         best_rho_q   <= '0;
         best_theta_q <= '0;
         best_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (busy_q) begin
                  // Done cycle: busy is still high, so strobes are ignored.
                  busy_q <= 1'b0;
               end else if (clear_i) begin
                  busy_q  <= 1'b1;
                  state_q <= S_CLEAR;
               end else if (vote_i || search_i) begin
                  busy_q     <= 1'b1;
                  is_vote_q  <= vote_i;
                  key_q      <= {theta_i, rho_i};
                  ptr_q      <= head_q;
                  prev_vld_q <= 1'b0;
                  at_tail_q  <= 1'b0;
                  state_q    <= (len_q == '0) ? S_MISS : S_SCAN;
               end else if (show_i) begin
                  busy_q  <= 1'b1;
                  addr_q  <= addr_i;
                  state_q <= S_SHOW;
               end
            end
            S_SCAN: begin
               if (cur_key == key_q) begin
                  state_q <= S_HIT;
               end else if ((SORTED != 0) && (cur_key > key_q)) begin
                  at_tail_q <= 1'b0;   // insert in front of ptr
                  state_q   <= S_MISS;
               end else if (ptr_q == tail_q) begin
                  at_tail_q <= 1'b1;
                  state_q   <= S_MISS;
               end else begin
                  prev_q     <= ptr_q;
                  prev_vld_q <= 1'b1;
                  ptr_q      <= next_mem[ptr_ix];
               end
            end
            S_HIT: begin
               done_q     <= 1'b1;
               found_q    <= 1'b1;
               overflow_q <= 1'b0;
               slot_q     <= ptr_q;
               next_q     <= '0;
               if (is_vote_q) begin
                  cnt_mem[ptr_ix] <= inc_cnt;
                  cnt_q           <= inc_cnt;
                  // Strictly greater: the earlier cell keeps ties, and a
                  // saturated count can never exceed the best again.
                  if (inc_cnt > best_cnt_q) begin
                     best_cnt_q   <= inc_cnt;
                     best_rho_q   <= key_q[RHO_W-1:0];
                     best_theta_q <= key_q[KEY_W-1:RHO_W];
                  end
               end else begin
                  cnt_q <= cur_cnt;
               end
               state_q <= S_IDLE;
            end
            S_MISS: begin
               done_q  <= 1'b1;
               found_q <= 1'b0;
               next_q  <= '0;
               if (!is_vote_q) begin
                  overflow_q <= 1'b0;
                  cnt_q      <= '0;
                  slot_q     <= '0;
               end else if (list_full) begin
                  overflow_q <= 1'b1;
                  cnt_q      <= '0;
                  slot_q     <= '0;
               end else begin
                  overflow_q      <= 1'b0;
                  key_mem[new_ix] <= key_q;
                  cnt_mem[new_ix] <= CNT_W'(1);
                  len_q           <= len_q + (ADDR_W + 1)'(1);
                  cnt_q           <= CNT_W'(1);
                  slot_q          <= new_slot;
                  if (len_q == '0) begin
                     head_q           <= new_slot;
                     tail_q           <= new_slot;
                     next_mem[new_ix] <= '0;
                  end else if (at_tail_q) begin
                     next_mem[tail_ix] <= new_slot;
                     next_mem[new_ix]  <= '0;
                     tail_q            <= new_slot;
                  end else begin
                     next_mem[new_ix] <= ptr_q;
                     if (prev_vld_q) begin
                        next_mem[prev_ix] <= new_slot;
                     end else begin
                        head_q <= new_slot;
                     end
                  end
                  if (best_cnt_q == '0) begin
                     best_cnt_q   <= CNT_W'(1);
                     best_rho_q   <= key_q[RHO_W-1:0];
                     best_theta_q <= key_q[KEY_W-1:RHO_W];
                  end
               end
               state_q <= S_IDLE;
            end
            S_SHOW: begin
               done_q     <= 1'b1;
               overflow_q <= 1'b0;
               slot_q     <= addr_q;
               found_q    <= show_vld;
               cnt_q      <= show_vld ? cnt_mem[addr_ix]  : '0;
               next_q     <= show_vld ? next_mem[addr_ix] : '0;
               state_q    <= S_IDLE;
            end
            S_CLEAR: begin
               done_q       <= 1'b1;
               found_q      <= 1'b0;
               overflow_q   <= 1'b0;
               cnt_q        <= '0;
               slot_q       <= '0;
               next_q       <= '0;
               len_q        <= '0;
               head_q       <= '0;
               tail_q       <= '0;
               best_cnt_q   <= '0;
               best_rho_q   <= '0;
               best_theta_q <= '0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign found_o      = found_q;
   assign overflow_o   = overflow_q;
   assign cnt_o        = cnt_q;
   assign slot_o       = slot_q;
   assign next_o       = next_q;
   assign len_o        = len_q;
   assign best_rho_o   = best_rho_q;
   assign best_theta_o = best_theta_q;
   assign best_cnt_o   = best_cnt_q;

endmodule

// File: tb/tb_ht_vote_list.sv
// Testbench for ht_vote_list with a small, saturating configuration
// (DEPTH = 4, CNT_W = 2, SORTED = 1). Expected values come from a
// queue-based model of the logical list.
module tb_ht_vote_list;

   localparam int RHO_W   = 10;
   localparam int THETA_W = 8;
   localparam int CNT_W   = 2;
   localparam int DEPTH   = 4;
   localparam int ADDR_W  = 2;
   localparam int CNT_MAX = 3;

   logic               clk, rst;
   logic [RHO_W-1:0]   rho_i;
   logic [THETA_W-1:0] theta_i;
   logic               vote_i, search_i, show_i, clear_i;
   logic [ADDR_W-1:0]  addr_i;
   logic               busy_o, done_o, found_o, overflow_o;
   logic [CNT_W-1:0]   cnt_o;
   logic [ADDR_W-1:0]  slot_o, next_o;
   logic [ADDR_W:0]    len_o;
   logic [RHO_W-1:0]   best_rho_o;
   logic [THETA_W-1:0] best_theta_o;
   logic [CNT_W-1:0]   best_cnt_o;

   int n_chk  = 0;
   int n_pass = 0;

   ht_vote_list #(
      .RHO_W(RHO_W), .THETA_W(THETA_W), .CNT_W(CNT_W),
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SORTED(1)
   ) dut (
      .clk(clk), .rst(rst), .rho_i(rho_i), .theta_i(theta_i),
      .vote_i(vote_i), .search_i(search_i), .show_i(show_i), .clear_i(clear_i),
      .addr_i(addr_i), .busy_o(busy_o), .done_o(done_o), .found_o(found_o),
      .overflow_o(overflow_o), .cnt_o(cnt_o), .slot_o(slot_o), .next_o(next_o),
      .len_o(len_o), .best_rho_o(best_rho_o), .best_theta_o(best_theta_o),
      .best_cnt_o(best_cnt_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // order_q holds physical slots in logical (ascending key) order.
   logic [17:0] m_key [DEPTH];
   int          m_cnt [DEPTH];
   int          order_q[$];
   logic [17:0] m_best_key;
   int          m_best_cnt;

   task automatic m_clear();
      order_q.delete();
      m_best_key = '0;
      m_best_cnt = 0;
   endtask

   // pos = hit position, or insertion position on a miss; c = nodes compared
   task automatic m_lookup(input logic [17:0] k, output int pos, output int c, output bit hit);
      hit = 0; c = 0; pos = order_q.size();
      for (int i = 0; i < order_q.size(); i++) begin
         c++;
         if (m_key[order_q[i]] == k) begin hit = 1; pos = i; return; end
         if (m_key[order_q[i]] > k) begin pos = i; return; end
      end
   endtask

   task automatic m_vote(input logic [17:0] k, output bit hit, output bit ovf,
                         output int slot, output int cnt, output int c);
      int pos;
      m_lookup(k, pos, c, hit);
      ovf = 0; slot = 0; cnt = 0;
      if (hit) begin
         slot = order_q[pos];
         if (m_cnt[slot] < CNT_MAX) m_cnt[slot]++;
         cnt = m_cnt[slot];
      end else if (order_q.size() == DEPTH) begin
         ovf = 1;
      end else begin
         slot = order_q.size();
         m_key[slot] = k;
         m_cnt[slot] = 1;
         order_q.insert(pos, slot);
         cnt = 1;
      end
      if (!ovf && cnt > m_best_cnt) begin
         m_best_cnt = cnt;
         m_best_key = k;
      end
   endtask

   task automatic m_search(input logic [17:0] k, output bit hit, output int slot,
                           output int cnt, output int c);
      int pos;
      m_lookup(k, pos, c, hit);
      slot = hit ? order_q[pos] : 0;
      cnt  = hit ? m_cnt[slot] : 0;
   endtask

   task automatic m_show(input int a, output bit vld, output int cnt,
                         output bit has_nxt, output int nxt);
      vld = (a < order_q.size());
      cnt = 0; has_nxt = 0; nxt = 0;
      if (vld) begin
         cnt = m_cnt[a];
         for (int i = 0; i < order_q.size(); i++)
            if (order_q[i] == a && i + 1 < order_q.size()) begin
               has_nxt = 1;
               nxt = order_q[i+1];
            end
      end
   endtask

   // ---------------- driver ----------------
   // Issues one command (any strobe combination) in a free cycle and waits
   // for done_o. lat is done cycle minus accept cycle, -1 on timeout.
   task automatic run_cmd(input logic v, input logic s, input logic sh, input logic cl,
                          input logic [RHO_W-1:0] r, input logic [THETA_W-1:0] t,
                          input logic [ADDR_W-1:0] a, output int lat, output int busy_bad);
      @(posedge clk); #1;
      @(negedge clk);
      vote_i = v; search_i = s; show_i = sh; clear_i = cl;
      rho_i = r; theta_i = t; addr_i = a;
      @(posedge clk); #1;
      vote_i = 0; search_i = 0; show_i = 0; clear_i = 0;
      lat = -1; busy_bad = 0;
      for (int n = 1; n <= 40; n++) begin
         if (!busy_o) busy_bad++;
         @(posedge clk); #1;
         if (done_o) begin
            lat = n + 1;
            if (!busy_o) busy_bad++;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1;
      vote_i = 0; search_i = 0; show_i = 0; clear_i = 0;
      rho_i = '0; theta_i = '0; addr_i = '0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if ({busy_o, done_o, found_o, overflow_o, cnt_o, slot_o, next_o} !== '0)
         $display("FAIL reset_flags got %b want 0", {busy_o, done_o, found_o, overflow_o, cnt_o, slot_o, next_o}); else n_pass++;
      n_chk++; if (len_o !== '0) $display("FAIL reset_len got %0d want 0", len_o); else n_pass++;
      n_chk++; if ({best_rho_o, best_theta_o, best_cnt_o} !== '0)
         $display("FAIL reset_best got %0d/%0d/%0d want 0", best_rho_o, best_theta_o, best_cnt_o); else n_pass++;
      @(negedge clk); rst = 0;
      m_clear();
   endtask

   task automatic test_sorted_build();
      logic [RHO_W-1:0] tbl [4] = '{10'd123, 10'd123, 10'd321, 10'd50};
      int lat, bb, slot, cnt, c, nxt;
      bit hit, ovf, vld, has_nxt;
      for (int i = 0; i < 4; i++) begin
         m_vote({8'd0, tbl[i]}, hit, ovf, slot, cnt, c);
         run_cmd(1, 0, 0, 0, tbl[i], 8'd0, 2'd0, lat, bb);
         n_chk++; if (lat !== 2 + c) $display("FAIL build_lat[%0d] got %0d want %0d", i, lat, 2 + c); else n_pass++;
         n_chk++; if (bb !== 0) $display("FAIL build_busy[%0d] got %0d low cycles want 0", i, bb); else n_pass++;
         n_chk++; if (cnt_o !== CNT_W'(cnt) || slot_o !== ADDR_W'(slot) || found_o !== hit)
            $display("FAIL build_res[%0d] got cnt %0d slot %0d found %0d want %0d %0d %0d", i, cnt_o, slot_o, found_o, cnt, slot, hit); else n_pass++;
         @(posedge clk); #1;
         n_chk++; if (best_cnt_o !== CNT_W'(m_best_cnt) || {best_theta_o, best_rho_o} !== m_best_key)
            $display("FAIL build_best[%0d] got %0d@%0d want %0d@%0d", i, best_cnt_o, best_rho_o, m_best_cnt, m_best_key); else n_pass++;
      end
      n_chk++; if (len_o !== 3'd3) $display("FAIL build_len got %0d want 3", len_o); else n_pass++;
      for (int a = 0; a < 4; a++) begin
         m_show(a, vld, cnt, has_nxt, nxt);
         run_cmd(0, 0, 1, 0, '0, '0, ADDR_W'(a), lat, bb);
         n_chk++; if (lat !== 2 || found_o !== vld || cnt_o !== CNT_W'(cnt) || slot_o !== ADDR_W'(a))
            $display("FAIL show[%0d] got lat %0d found %0d cnt %0d slot %0d want 2 %0d %0d %0d", a, lat, found_o, cnt_o, slot_o, vld, cnt, a); else n_pass++;
         if (has_nxt || !vld) begin
            n_chk++; if (next_o !== ADDR_W'(nxt)) $display("FAIL show_next[%0d] got %0d want %0d", a, next_o, nxt); else n_pass++;
         end
      end
   endtask

   task automatic test_search_latency();
      logic [RHO_W-1:0] tbl [3] = '{10'd123, 10'd789, 10'd100};
      int lat, bb, slot, cnt, c;
      bit hit;
      for (int i = 0; i < 3; i++) begin
         m_search({8'd0, tbl[i]}, hit, slot, cnt, c);
         run_cmd(0, 1, 0, 0, tbl[i], 8'd0, 2'd0, lat, bb);
         n_chk++; if (lat !== 2 + c) $display("FAIL search_lat[%0d] got %0d want %0d", i, lat, 2 + c); else n_pass++;
         n_chk++; if (found_o !== hit || cnt_o !== CNT_W'(cnt))
            $display("FAIL search_res[%0d] got found %0d cnt %0d want %0d %0d", i, found_o, cnt_o, hit, cnt); else n_pass++;
      end
   endtask

   task automatic test_overflow();
      logic [RHO_W-1:0] tbl [2] = '{10'd700, 10'd999};
      int lat, bb, slot, cnt, c;
      bit hit, ovf;
      for (int i = 0; i < 2; i++) begin
         m_vote({8'd0, tbl[i]}, hit, ovf, slot, cnt, c);
         run_cmd(1, 0, 0, 0, tbl[i], 8'd0, 2'd0, lat, bb);
         n_chk++; if (lat !== 2 + c || overflow_o !== ovf || found_o !== 1'b0)
            $display("FAIL ovf_res[%0d] got lat %0d ovf %0d found %0d want %0d %0d 0", i, lat, overflow_o, found_o, 2 + c, ovf); else n_pass++;
         n_chk++; if (len_o !== 3'(order_q.size())) $display("FAIL ovf_len[%0d] got %0d want %0d", i, len_o, order_q.size()); else n_pass++;
      end
      for (int i = 0; i < DEPTH; i++) begin
         m_search(m_key[i], hit, slot, cnt, c);
         run_cmd(0, 1, 0, 0, m_key[i][9:0], m_key[i][17:10], 2'd0, lat, bb);
         n_chk++; if (found_o !== hit || cnt_o !== CNT_W'(cnt) || slot_o !== ADDR_W'(slot))
            $display("FAIL ovf_keep[%0d] got found %0d cnt %0d slot %0d want %0d %0d %0d", i, found_o, cnt_o, slot_o, hit, cnt, slot); else n_pass++;
      end
   endtask

   task automatic test_saturation();
      int exp_seq [5] = '{1, 2, 3, 3, 3};
      int lat, bb, slot, cnt, c;
      bit hit, ovf;
      run_cmd(0, 0, 0, 1, '0, '0, '0, lat, bb);
      m_clear();
      for (int i = 0; i < 5; i++) begin
         m_vote({8'd1, 10'd5}, hit, ovf, slot, cnt, c);
         run_cmd(1, 0, 0, 0, 10'd5, 8'd1, 2'd0, lat, bb);
         n_chk++; if (cnt_o !== CNT_W'(exp_seq[i])) $display("FAIL sat_cnt[%0d] got %0d want %0d", i, cnt_o, exp_seq[i]); else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         m_vote({8'd1, 10'd6}, hit, ovf, slot, cnt, c);
         run_cmd(1, 0, 0, 0, 10'd6, 8'd1, 2'd0, lat, bb);
      end
      n_chk++; if (cnt_o !== 2'd3) $display("FAIL sat_second got %0d want 3", cnt_o); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (best_cnt_o !== 2'd3 || best_rho_o !== 10'd5 || best_theta_o !== 8'd1)
         $display("FAIL sat_best got %0d@%0d/%0d want 3@5/1", best_cnt_o, best_rho_o, best_theta_o); else n_pass++;
   endtask

   task automatic test_priority_clear();
      int lat, bb, slot, cnt, c;
      bit hit, ovf;
      run_cmd(0, 0, 0, 1, '0, '0, '0, lat, bb);
      m_clear();
      // vote + search: vote wins
      m_vote({8'd0, 10'd11}, hit, ovf, slot, cnt, c);
      run_cmd(1, 1, 0, 0, 10'd11, 8'd0, 2'd0, lat, bb);
      n_chk++; if (cnt_o !== 2'd1 || len_o !== 3'd1 || slot_o !== 2'd0)
         $display("FAIL prio_vote got cnt %0d len %0d slot %0d want 1 1 0", cnt_o, len_o, slot_o); else n_pass++;
      // search + show: search wins (show of slot 0 would report found)
      m_search({8'd0, 10'd12}, hit, slot, cnt, c);
      run_cmd(0, 1, 1, 0, 10'd12, 8'd0, 2'd0, lat, bb);
      n_chk++; if (found_o !== hit || lat !== 2 + c)
         $display("FAIL prio_search got found %0d lat %0d want %0d %0d", found_o, lat, hit, 2 + c); else n_pass++;
      // clear + vote: clear wins, visible in the done cycle
      run_cmd(1, 0, 0, 1, 10'd99, 8'd0, 2'd0, lat, bb);
      m_clear();
      n_chk++; if (lat !== 2 || len_o !== '0 || best_cnt_o !== '0 || best_rho_o !== '0)
         $display("FAIL prio_clear got lat %0d len %0d best %0d@%0d want 2 0 0@0", lat, len_o, best_cnt_o, best_rho_o); else n_pass++;
   endtask

   task automatic test_busy_ignore();
      int lat, bb, slot, cnt, c, dones;
      bit hit, ovf, res_found;
      logic [RHO_W-1:0] tbl [3] = '{10'd10, 10'd20, 10'd30};
      for (int i = 0; i < 3; i++) begin
         m_vote({8'd0, tbl[i]}, hit, ovf, slot, cnt, c);
         run_cmd(1, 0, 0, 0, tbl[i], 8'd0, 2'd0, lat, bb);
      end
      @(posedge clk); #1;
      @(negedge clk); rho_i = 10'd40; theta_i = '0; search_i = 1;
      @(posedge clk); #1; search_i = 0;
      dones = 0; res_found = 1;
      // Strobe mid-scan (n=1) and in the done cycle (n=4); both are ignored.
      for (int n = 0; n < 12; n++) begin
         vote_i = (n == 1 || n == 4);
         rho_i  = 10'd5;
         @(posedge clk); #1;
         if (done_o) begin dones++; res_found = found_o; end
      end
      vote_i = 0;
      n_chk++; if (dones !== 1) $display("FAIL busy_dones got %0d want 1", dones); else n_pass++;
      n_chk++; if (res_found !== 1'b0) $display("FAIL busy_found got %0d want 0", res_found); else n_pass++;
      n_chk++; if (len_o !== 3'(order_q.size())) $display("FAIL busy_len got %0d want %0d", len_o, order_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid_scan();
      int lat, bb, dones;
      @(posedge clk); #1;
      @(negedge clk); rho_i = 10'd40; theta_i = '0; search_i = 1;
      @(posedge clk); #1; search_i = 0;
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      n_chk++; if ({busy_o, done_o, found_o, overflow_o, cnt_o, slot_o, next_o, len_o, best_cnt_o} !== '0)
         $display("FAIL rst_mid_out got %b want 0", {busy_o, done_o, found_o, overflow_o, cnt_o, slot_o, next_o, len_o, best_cnt_o}); else n_pass++;
      @(negedge clk); rst = 0;
      dones = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         if (done_o) dones++;
      end
      n_chk++; if (dones !== 0) $display("FAIL rst_mid_done got %0d want 0", dones); else n_pass++;
      m_clear();
      run_cmd(1, 0, 0, 0, 10'd77, 8'd0, 2'd0, lat, bb);
      n_chk++; if (lat !== 2 || slot_o !== 2'd0 || cnt_o !== 2'd1 || len_o !== 3'd1)
         $display("FAIL rst_mid_vote got lat %0d slot %0d cnt %0d len %0d want 2 0 1 1", lat, slot_o, cnt_o, len_o); else n_pass++;
      begin
         bit hit, ovf; int slot, cnt, c;
         m_vote({8'd0, 10'd77}, hit, ovf, slot, cnt, c);
      end
   endtask

   task automatic test_random();
      int lat, bb, slot, cnt, c, nxt, op;
      bit hit, ovf, vld, has_nxt;
      logic [RHO_W-1:0] r;
      logic [THETA_W-1:0] t;
      logic [ADDR_W-1:0] a;
      run_cmd(0, 0, 0, 1, '0, '0, '0, lat, bb);
      m_clear();
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 9);
         r  = RHO_W'($urandom_range(0, 5) * 37);
         t  = THETA_W'($urandom_range(0, 1));
         a  = ADDR_W'($urandom_range(0, 3));
         if (op < 6) begin
            m_vote({t, r}, hit, ovf, slot, cnt, c);
            run_cmd(1, 0, 0, 0, r, t, a, lat, bb);
            n_chk++; if (lat !== 2 + c || found_o !== hit || overflow_o !== ovf)
               $display("FAIL rnd_vote[%0d] got lat %0d found %0d ovf %0d want %0d %0d %0d", i, lat, found_o, overflow_o, 2 + c, hit, ovf); else n_pass++;
            if (!ovf) begin
               n_chk++; if (cnt_o !== CNT_W'(cnt) || slot_o !== ADDR_W'(slot))
                  $display("FAIL rnd_vote_cs[%0d] got cnt %0d slot %0d want %0d %0d", i, cnt_o, slot_o, cnt, slot); else n_pass++;
            end
            n_chk++; if (len_o !== 3'(order_q.size())) $display("FAIL rnd_len[%0d] got %0d want %0d", i, len_o, order_q.size()); else n_pass++;
            @(posedge clk); #1;
            n_chk++; if (best_cnt_o !== CNT_W'(m_best_cnt) || {best_theta_o, best_rho_o} !== m_best_key)
               $display("FAIL rnd_best[%0d] got %0d@%0h want %0d@%0h", i, best_cnt_o, {best_theta_o, best_rho_o}, m_best_cnt, m_best_key); else n_pass++;
         end else if (op < 8) begin
            m_search({t, r}, hit, slot, cnt, c);
            run_cmd(0, 1, 0, 0, r, t, a, lat, bb);
            n_chk++; if (lat !== 2 + c || found_o !== hit || cnt_o !== CNT_W'(cnt))
               $display("FAIL rnd_search[%0d] got lat %0d found %0d cnt %0d want %0d %0d %0d", i, lat, found_o, cnt_o, 2 + c, hit, cnt); else n_pass++;
            if (hit) begin
               n_chk++; if (slot_o !== ADDR_W'(slot)) $display("FAIL rnd_search_slot[%0d] got %0d want %0d", i, slot_o, slot); else n_pass++;
            end
         end else begin
            m_show(int'(a), vld, cnt, has_nxt, nxt);
            run_cmd(0, 0, 1, 0, r, t, a, lat, bb);
            n_chk++; if (lat !== 2 || found_o !== vld || cnt_o !== CNT_W'(cnt) || slot_o !== a)
               $display("FAIL rnd_show[%0d] got lat %0d found %0d cnt %0d slot %0d want 2 %0d %0d %0d", i, lat, found_o, cnt_o, slot_o, vld, cnt, a); else n_pass++;
            if (has_nxt || !vld) begin
               n_chk++; if (next_o !== ADDR_W'(nxt)) $display("FAIL rnd_show_next[%0d] got %0d want %0d", i, next_o, nxt); else n_pass++;
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_sorted_build();
      test_search_latency();
      test_overflow();
      test_saturation();
      test_priority_clear();
      test_busy_ignore();
      test_reset_mid_scan();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "time limit");
   end

endmodule
